// File: rtl/atmega_uart_pkg.sv
// Shared definitions for the atmega_uart receive-side blocks: UCSRA bit map,
// drain FSM encoding and FIFO entry width.
package atmega_uart_pkg;

    localparam int unsigned UCSRA_RXC  = 7;
    localparam int unsigned UCSRA_TXC  = 6;
    localparam int unsigned UCSRA_UDRE = 5;
    localparam int unsigned UCSRA_FE   = 4;
    localparam int unsigned UCSRA_DOR  = 3;
    localparam int unsigned UCSRA_UPE  = 2;

    // FIFO entry layout: {DOR, FE, data[7:0]}
    localparam int unsigned ENTRY_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STAT = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } drain_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with a separate occupancy counter so that
// full and empty are unambiguous. Storage is intentionally not reset.
module sync_fifo #(
    parameter int unsigned WIDTH      = 10,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      din_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      dout_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   level_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_L = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2:0]   r_level;

    logic w_do_pop;
    logic w_do_push;

    assign full_o  = (r_level == DEPTH_L);
    assign empty_o = (r_level == '0);
    assign level_o = r_level;
    assign dout_o  = r_mem[r_rptr];

    // A pop in the same cycle frees the head slot, so a push at full still fits.
    assign w_do_pop  = pop_i & ~empty_o;
    assign w_do_push = push_i & (~full_o | w_do_pop);

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= din_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/atmega_uart_rx_drain.sv
// Drains received bytes from atmega_uart (UCSRA then UDR) into a local FIFO
// of {DOR, FE, data} entries for a consumer to pop at its own pace.
module atmega_uart_rx_drain
    import atmega_uart_pkg::*;
#(
    parameter int unsigned                  BUS_ADDR_DATA_LEN = 8,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] UDR_ADDR          = 'hc1,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] UCSRA_ADDR        = 'hc8,
    parameter int unsigned                  DEPTH_LOG2        = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         enable_i,
    input  logic                         uart_rxc_i,
    input  logic                         uart_gnt_i,
    output logic                         uart_req_o,
    output logic [BUS_ADDR_DATA_LEN-1:0] uart_addr_o,
    output logic                         uart_rd_o,
    input  logic [7:0]                   uart_dat_i,
    input  logic                         pop_i,
    output logic                         valid_o,
    output logic [7:0]                   data_o,
    output logic [1:0]                   status_o,
    output logic [DEPTH_LOG2:0]          level_o,
    output logic                         ovf_o,
    input  logic                         ovf_clr_i
);

    drain_state_t                 r_state;
    logic                         r_req;
    logic [BUS_ADDR_DATA_LEN-1:0] r_addr;
    logic                         r_fe;
    logic                         r_dor;
    logic                         r_ovf;

    logic                         w_push;
    logic                         w_full;
    logic                         w_empty;
    logic                         w_pop_ok;
    logic                         w_drop;
    logic [ENTRY_W-1:0]           w_din;
    logic [ENTRY_W-1:0]           w_dout;

    // The read strobe must coincide with the combinational bus data, so it
    // follows the grant directly rather than being registered.
    assign uart_rd_o   = uart_gnt_i & ((r_state == ST_STAT) | (r_state == ST_DATA));
    assign uart_req_o  = r_req;
    assign uart_addr_o = r_addr;

    assign w_push   = uart_gnt_i & (r_state == ST_DATA);
    assign w_pop_ok = pop_i & ~w_empty;
    assign w_drop   = w_push & w_full & ~w_pop_ok;
    assign w_din    = {r_dor, r_fe, uart_dat_i};

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_addr  <= '0;
            r_fe    <= 1'b0;
            r_dor   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (uart_rxc_i && enable_i) begin
                        r_state <= ST_STAT;
                        r_req   <= 1'b1;
                        r_addr  <= UCSRA_ADDR;
                    end
                end
                ST_STAT: begin
                    if (uart_gnt_i) begin
                        r_fe    <= uart_dat_i[UCSRA_FE];
                        r_dor   <= uart_dat_i[UCSRA_DOR];
                        r_state <= ST_DATA;
                        r_addr  <= UDR_ADDR;
                    end
                end
                ST_DATA: begin
                    if (uart_gnt_i) begin
                        r_state <= ST_GAP;
                        r_req   <= 1'b0;
                        r_addr  <= '0;
                    end
                end
                ST_GAP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                    r_addr  <= '0;
                end
            endcase
        end
    end

    // A fresh overflow takes priority over a simultaneous clear.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr_i) begin
            r_ovf <= 1'b0;
        end
    end

    assign ovf_o    = r_ovf;
    assign valid_o  = ~w_empty;
    assign data_o   = w_dout[7:0];
    assign status_o = w_dout[9:8];

    sync_fifo #(
        .WIDTH      (ENTRY_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .din_i   (w_din),
        .pop_i   (pop_i),
        .dout_o  (w_dout),
        .full_o  (w_full),
        .empty_o (w_empty),
        .level_o (level_o)
    );

endmodule
